id_exe_reg: RTL and testbench
=============================

# id_exe_reg

Pipeline register between the decode stage and the execute stage of the 5-stage RV32I core. It latches the decoded operands, immediate, destination register and control word, and drives `rd_EXE` back to the decode-stage forwarding decoder. It also owns load-use hazard detection. On a load-use hazard it asserts `stall_id` to freeze PC and IF/ID, injects one bubble into execute, and counts the bubbles it inserts.

## Interface
Parameters:
- CTRL_W, 12, width of the opaque execute/memory/writeback control word
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_pc  in  32  PC of decode instruction
- id_rs1_data  in  32  rs1 operand after decode forwarding mux
- id_rs2_data  in  32  rs2 operand after decode forwarding mux
- id_imm  in  32  sign-extended immediate
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_rd  in  5  destination register index
- id_ctrl  in  CTRL_W  control word, passed through untouched
- id_mem_read  in  1  decode instruction is a load
- id_reg_write  in  1  decode instruction writes rd
- flush  in  1  kill the decode instruction (trap/redirect)
- ext_stall  in  1  downstream stall, hold this register
- exe_valid  out  1  execute holds a real instruction
- exe_pc, exe_rs1_data, exe_rs2_data, exe_imm  out  32 each  registered copies
- rd_EXE  out  5  execute destination, forced to 0 when not valid
- exe_ctrl  out  CTRL_W  registered control word
- exe_mem_read, exe_reg_write  out  1 each  registered, forced to 0 on bubble
- stall_id  out  1  freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Load-use detect, combinational: `lu = exe_valid & exe_mem_read & (rd_EXE != 0) & id_valid & (id_rs1 == rd_EXE | id_rs2 == rd_EXE)`.
- `stall_id = ext_stall | (lu & ~flush)`.
- Per-edge priority:
  1. rst: all outputs 0, bubble_cnt 0.
  2. ext_stall: every register holds. bubble_cnt holds.
  3. flush: load a bubble.
  4. lu: load a bubble, bubble_cnt += 1, saturating at all-ones.
  5. Otherwise: load all id_* fields. exe_valid = id_valid. rd_EXE, exe_mem_read and exe_reg_write are gated by id_valid.
- Bubble definition:
  - exe_valid, rd_EXE, exe_mem_read, exe_reg_write = 0.
  - exe_ctrl = 0, which decodes as NOP.
  - Data fields = 0, so a MEM forward of x0 yields 0.
- A stalled decode instruction is re-presented by IF/ID next cycle. After one bubble the load sits in MEM, so `lu` deasserts and MEM forwarding supplies the operand.
- Back-to-back loads: load B following load A with dependency → exactly one bubble each time lu is true.

## Timing
- Latency: one cycle from id_* to exe_* when not stalled or flushed.
- stall_id is combinational from registered state and decode inputs. There is no flop on that path, and it must settle before the IF/ID enable.
- Load-use with a dependent instruction produces exactly one stall cycle and one bubble.
- flush and lu in the same cycle: flush wins. The bubble is not counted, and stall_id = ext_stall.
- ext_stall overlapping lu: the register holds and stall_id = 1. The bubble is inserted on the first edge after ext_stall drops, provided lu is still true.
- Reset mid-stall: the next cycle shows exe_valid = 0, stall_id = lu-free, bubble_cnt = 0.

## Structure
- Shared pipeline package `core_pkg`: CTRL_W, the control-word field offsets, the NOP control constant (0), and the REG_ZERO index.
- One natural sub-module, `load_use_detect`: combinational lu from exe_valid, exe_mem_read, rd_EXE, id_valid, id_rs1 and id_rs2. The flops and counter stay in `id_exe_reg`.

## Test plan
- Plain pass-through: id_pc=0x100, id_rd=5, id_valid=1, no stalls → next cycle exe_pc=0x100, rd_EXE=5, exe_valid=1, stall_id=0.
- Load-use: lw x7 in EXE, decode add with rs1=7 → stall_id=1 for one cycle. The next edge yields exe_valid=0 and rd_EXE=0. bubble_cnt goes 0→1. The following cycle loads the add.
- x0 / no-dependency: load into rd=0 with decode rs1=0, and a separate load into rd=7 with decode rs1=3, rs2=4 → stall_id=0 and no bubble in both cases.
- Flush priority: lu true and flush=1 on the same cycle → bubble inserted, stall_id=0, bubble_cnt unchanged.
- ext_stall hold: assert for 3 cycles with changing id_* → exe_* constant and stall_id=1 throughout. Release → the current id_* is loaded on the next edge.
- Saturation and reset: drive CNT_W=4 with 20 load-use events → bubble_cnt sticks at 15. Then assert rst for 1 cycle → all outputs 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared pipeline constants for the RV32I core
package core_pkg;
  localparam int CTRL_W = 12;
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W = 4;
  localparam int CTRL_ALU_SRC_BIT = 4;
  localparam int CTRL_BRANCH_BIT = 5;
  localparam int CTRL_JUMP_BIT = 6;
  localparam int CTRL_MEM_WRITE_BIT = 7;
  localparam int CTRL_MEM_SIZE_LSB = 8;
  localparam int CTRL_MEM_SIZE_W = 2;
  localparam int CTRL_WB_SEL_LSB = 10;
  localparam int CTRL_WB_SEL_W = 2;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode instruction that reads the result of a load still in execute
module load_use_detect
  import core_pkg::*;
(
  input  logic       exe_valid,
  input  logic       exe_mem_read,
  input  logic [4:0] rd_exe,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       lu
);
  assign lu = exe_valid & exe_mem_read & (rd_exe != REG_ZERO) & id_valid &
              ((id_rs1 == rd_exe) | (id_rs2 == rd_exe));
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: decode-to-execute pipeline register with load-use bubble insertion and bubble counter
module id_exe_reg
  import core_pkg::*;
#(
  parameter int CTRL_W = core_pkg::CTRL_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              exe_valid,
  output logic [31:0]       exe_pc,
  output logic [31:0]       exe_rs1_data,
  output logic [31:0]       exe_rs2_data,
  output logic [31:0]       exe_imm,
  output logic [4:0]        rd_EXE,
  output logic [CTRL_W-1:0] exe_ctrl,
  output logic              exe_mem_read,
  output logic              exe_reg_write,
  output logic              stall_id,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic lu;
  load_use_detect u_lu (
    .exe_valid    (exe_valid),
    .exe_mem_read (exe_mem_read),
    .rd_exe       (rd_EXE),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .lu           (lu)
  );
  assign stall_id = ext_stall | (lu & ~flush);
  // stage register: hold on ext_stall, bubble on flush or load-use, else capture decode
  always_ff @(posedge clk) begin
    if (rst | (~ext_stall & (flush | lu))) begin
      exe_valid     <= 1'b0;
      exe_pc        <= '0;
      exe_rs1_data  <= '0;
      exe_rs2_data  <= '0;
      exe_imm       <= '0;
      rd_EXE        <= REG_ZERO;
      exe_ctrl      <= CTRL_NOP[CTRL_W-1:0];
      exe_mem_read  <= 1'b0;
      exe_reg_write <= 1'b0;
    end else if (!ext_stall) begin
      exe_valid     <= id_valid;
      exe_pc        <= id_pc;
      exe_rs1_data  <= id_rs1_data;
      exe_rs2_data  <= id_rs2_data;
      exe_imm       <= id_imm;
      rd_EXE        <= id_valid ? id_rd : REG_ZERO;
      exe_ctrl      <= id_ctrl;
      exe_mem_read  <= id_valid & id_mem_read;
      exe_reg_write <= id_valid & id_reg_write;
    end
  end
  // saturating count of load-use bubbles; flushed bubbles are not counted
  always_ff @(posedge clk) begin
    if (rst) bubble_cnt <= '0;
    else if (~ext_stall & ~flush & lu & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed self-checking bench for id_exe_reg
module tb_id_exe_reg;
  logic        clk = 0, rst = 0;
  logic        id_valid = 0, id_mem_read = 0, id_reg_write = 0, flush = 0, ext_stall = 0;
  logic [31:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [11:0] id_ctrl = 0;
  logic        exe_valid, exe_mem_read, exe_reg_write, stall_id;
  logic [31:0] exe_pc, exe_rs1_data, exe_rs2_data, exe_imm;
  logic [4:0]  rd_EXE;
  logic [11:0] exe_ctrl;
  logic [3:0]  bubble_cnt;
  int checks = 0, errors = 0, exp_cnt = 0;

  id_exe_reg #(.CTRL_W(12), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .ext_stall(ext_stall), .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_rs1_data(exe_rs1_data),
    .exe_rs2_data(exe_rs2_data), .exe_imm(exe_imm), .rd_EXE(rd_EXE), .exe_ctrl(exe_ctrl),
    .exe_mem_read(exe_mem_read), .exe_reg_write(exe_reg_write), .stall_id(stall_id),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic rw, input logic [11:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_mem_read = mr; id_reg_write = rw; id_ctrl = ctrl;
    id_rs1_data = pc + 32'h1000; id_rs2_data = pc + 32'h2000; id_imm = pc + 32'h3000;
    #1;
  endtask

  initial begin
    rst = 1;
    tick();
    rst = 0;
    chk("rst_valid", {31'd0, exe_valid}, 0);
    chk("rst_pc", exe_pc, 0);
    chk("rst_rd", {27'd0, rd_EXE}, 0);
    chk("rst_ctrl", {20'd0, exe_ctrl}, 0);
    chk("rst_cnt", {28'd0, bubble_cnt}, 0);
    chk("rst_stall", {31'd0, stall_id}, 0);

    set_id(1, 32'h100, 1, 2, 5, 0, 1, 12'hABC);
    chk("pt_stall", {31'd0, stall_id}, 0);
    tick();
    chk("pt_pc", exe_pc, 32'h100);
    chk("pt_rd", {27'd0, rd_EXE}, 5);
    chk("pt_valid", {31'd0, exe_valid}, 1);
    chk("pt_rs1d", exe_rs1_data, 32'h1100);
    chk("pt_imm", exe_imm, 32'h3100);
    chk("pt_ctrl", {20'd0, exe_ctrl}, 32'hABC);
    chk("pt_rw", {31'd0, exe_reg_write}, 1);

    set_id(0, 32'h104, 1, 2, 6, 1, 1, 12'h123);
    tick();
    chk("inv_valid", {31'd0, exe_valid}, 0);
    chk("inv_rd", {27'd0, rd_EXE}, 0);
    chk("inv_mr", {31'd0, exe_mem_read}, 0);
    chk("inv_pc", exe_pc, 32'h104);

    set_id(1, 32'h108, 0, 0, 7, 1, 1, 12'h111);
    tick();
    chk("lw_mr", {31'd0, exe_mem_read}, 1);
    set_id(1, 32'h10c, 7, 2, 8, 0, 1, 12'h222);
    chk("lu_stall", {31'd0, stall_id}, 1);
    tick();
    exp_cnt = 1;
    chk("lu_bub_valid", {31'd0, exe_valid}, 0);
    chk("lu_bub_rd", {27'd0, rd_EXE}, 0);
    chk("lu_bub_ctrl", {20'd0, exe_ctrl}, 0);
    chk("lu_bub_pc", exe_pc, 0);
    chk("lu_bub_rw", {31'd0, exe_reg_write}, 0);
    chk("lu_cnt", {28'd0, bubble_cnt}, exp_cnt);
    chk("lu_stall_off", {31'd0, stall_id}, 0);
    tick();
    chk("lu_add_pc", exe_pc, 32'h10c);
    chk("lu_add_rd", {27'd0, rd_EXE}, 8);

    set_id(1, 32'h110, 0, 0, 0, 1, 1, 12'h111);
    tick();
    set_id(1, 32'h114, 0, 0, 9, 0, 1, 12'h222);
    chk("x0_stall", {31'd0, stall_id}, 0);
    tick();
    chk("x0_valid", {31'd0, exe_valid}, 1);
    chk("x0_cnt", {28'd0, bubble_cnt}, exp_cnt);
    set_id(1, 32'h118, 0, 0, 7, 1, 1, 12'h111);
    tick();
    set_id(1, 32'h11c, 3, 4, 9, 0, 1, 12'h222);
    chk("nodep_stall", {31'd0, stall_id}, 0);
    tick();
    chk("nodep_pc", exe_pc, 32'h11c);
    chk("nodep_cnt", {28'd0, bubble_cnt}, exp_cnt);

    set_id(1, 32'h120, 0, 0, 7, 1, 1, 12'h111);
    tick();
    set_id(1, 32'h124, 1, 7, 9, 0, 1, 12'h222);
    flush = 1;
    #1;
    chk("fl_stall", {31'd0, stall_id}, 0);
    tick();
    flush = 0;
    chk("fl_valid", {31'd0, exe_valid}, 0);
    chk("fl_pc", exe_pc, 0);
    chk("fl_cnt", {28'd0, bubble_cnt}, exp_cnt);

    set_id(1, 32'h200, 0, 0, 10, 1, 1, 12'h333);
    tick();
    ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h204 + 4 * i, 1, 10, 11, 0, 1, 12'h444);
      chk("es_stall", {31'd0, stall_id}, 1);
      tick();
      chk("es_pc", exe_pc, 32'h200);
      chk("es_rd", {27'd0, rd_EXE}, 10);
      chk("es_cnt", {28'd0, bubble_cnt}, exp_cnt);
    end
    set_id(1, 32'h210, 1, 2, 12, 0, 1, 12'h555);
    ext_stall = 0;
    #1;
    chk("es_rel_stall", {31'd0, stall_id}, 0);
    tick();
    chk("es_rel_pc", exe_pc, 32'h210);
    chk("es_rel_rd", {27'd0, rd_EXE}, 12);

    set_id(1, 32'h300, 0, 0, 13, 1, 1, 12'h111);
    tick();
    ext_stall = 1;
    set_id(1, 32'h304, 13, 0, 14, 0, 1, 12'h222);
    tick();
    chk("ov_stall", {31'd0, stall_id}, 1);
    chk("ov_hold_rd", {27'd0, rd_EXE}, 13);
    ext_stall = 0;
    #1;
    chk("ov_rel_stall", {31'd0, stall_id}, 1);
    tick();
    exp_cnt = 2;
    chk("ov_bub_valid", {31'd0, exe_valid}, 0);
    chk("ov_cnt", {28'd0, bubble_cnt}, exp_cnt);

    for (int i = 0; i < 20; i++) begin
      set_id(1, 32'h400 + 8 * i, 0, 0, 7, 1, 1, 12'h111);
      tick();
      set_id(1, 32'h404 + 8 * i, 2, 7, 8, 0, 1, 12'h222);
      tick();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      chk("sat_cnt", {28'd0, bubble_cnt}, exp_cnt);
    end
    chk("sat_final", {28'd0, bubble_cnt}, 15);

    set_id(1, 32'h500, 0, 0, 7, 1, 1, 12'h111);
    tick();
    set_id(1, 32'h504, 7, 0, 8, 0, 1, 12'h222);
    chk("prerst_stall", {31'd0, stall_id}, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst2_valid", {31'd0, exe_valid}, 0);
    chk("rst2_rd", {27'd0, rd_EXE}, 0);
    chk("rst2_pc", exe_pc, 0);
    chk("rst2_mr", {31'd0, exe_mem_read}, 0);
    chk("rst2_cnt", {28'd0, bubble_cnt}, 0);
    chk("rst2_stall", {31'd0, stall_id}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
